// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared FSM state type, {l,s} operation codes and carry-seed helper.
// Optional feature macro used by the block: ALU_SERIAL_FLAGS_EN (zf/vf flag outputs).
package alu_serial_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_ADC = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    // Carry seeded into bit 0: SUB and INC add an implicit 1, ADC uses c_in.
    function automatic logic init_carry(input logic [2:0] op, input logic c_in);
        return (op == OP_SUB) || (op == OP_INC) || ((op == OP_ADC) && c_in);
    endfunction

endpackage

// File: rtl/alu_bit_cell.sv
// alu_bit_cell: combinational 1-bit logic/adder slice of the serial ALU.
// Ports: a, b, cin - operand bits and incoming carry; l, s - mode/operation;
//        r - result bit; cout - carry out (0 in logic mode).
module alu_bit_cell
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       l,
    input  logic [1:0] s,
    output logic       r,
    output logic       cout
);

    logic [2:0] op;
    logic       bb;
    logic       sum_r;
    logic       sum_c;
    logic       log_r;

    always_comb begin
        op    = {l, s};
        // SUB adds the inverted operand; INC adds nothing but the seeded carry.
        bb    = (op == OP_SUB) ? ~b : (op == OP_INC) ? 1'b0 : b;
        sum_r = a ^ bb ^ cin;
        sum_c = (a & bb) | (cin & (a ^ bb));
        log_r = (s == 2'b00) ? (a & b) : (s == 2'b01) ? (a | b) : (s == 2'b10) ? (a ^ b) : ~a;
        r     = l ? sum_r : log_r;
        cout  = l & sum_c;
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial LSB-first ALU, one bit per clock through a single alu_bit_cell.
// Ports: clk, rst_n (async active-low); start/a/b/l/s/c_in request captured in IDLE;
//        busy (BUSY or DONE), done (one-cycle result strobe), y/c_out result registers;
//        zf/vf zero and signed-overflow flags only when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             l,
    input  logic [1:0]       s,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zf,
    output logic             vf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             l_q, l_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_out_q, c_out_d;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             zf_q, zf_d;
    logic             vf_q, vf_d;
`endif
    logic             cell_r;
    logic             cell_cout;
    logic [WIDTH-1:0] res;

    alu_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .l    (l_q),
        .s    (s_q),
        .r    (cell_r),
        .cout (cell_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        l_d     = l_q;
        s_d     = s_q;
        y_d     = y_q;
        c_out_d = c_out_q;
`ifdef ALU_SERIAL_FLAGS_EN
        zf_d    = zf_q;
        vf_d    = vf_q;
`endif
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        res     = {cell_r, r_q[WIDTH-1:1]};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    l_d     = l;
                    s_d     = s;
                    carry_d = init_carry({l, s}, c_in);
                end
            end
            BUSY: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                r_d     = res;
                carry_d = cell_cout;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    y_d     = res;
                    c_out_d = cell_cout;
`ifdef ALU_SERIAL_FLAGS_EN
                    zf_d    = (res == '0);
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    vf_d    = l_q & (carry_q ^ cell_cout);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            l_q     <= 1'b0;
            s_q     <= 2'b00;
            y_q     <= '0;
            c_out_q <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zf_q    <= 1'b0;
            vf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            l_q     <= l_d;
            s_q     <= s_d;
            y_q     <= y_d;
            c_out_q <= c_out_d;
`ifdef ALU_SERIAL_FLAGS_EN
            zf_q    <= zf_d;
            vf_q    <= vf_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign y     = y_q;
    assign c_out = c_out_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zf    = zf_q;
    assign vf    = vf_q;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed 8-bit vectors plus a 32-bit back-to-back ADD/SUB run for alu_serial.
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        l8 = 1'b0, ci8 = 1'b0;
    logic [1:0]  s8 = '0;
    logic        busy8, done8, c8;
    logic [7:0]  y8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        l32 = 1'b1, ci32 = 1'b0;
    logic [1:0]  s32 = '0;
    logic        busy32, done32, c32;
    logic [31:0] y32;

`ifdef ALU_SERIAL_FLAGS_EN
    logic        zf8, vf8, zf32, vf32;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  prev_y = '0;
    logic [31:0] q_y[$];
    logic        q_c[$];
    int          pushed = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .l(l8), .s(s8), .c_in(ci8),
        .busy(busy8), .done(done8), .y(y8), .c_out(c8)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zf(zf8), .vf(vf8)
`endif
    );

    alu_serial #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .l(l32), .s(s32), .c_in(ci32),
        .busy(busy32), .done(done32), .y(y32), .c_out(c32)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zf(zf32), .vf(vf32)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation: drive, accept, scramble inputs, await done, check result and timing.
    task automatic run8(input string tag, input logic li, input logic [1:0] si, input logic ci,
                        input logic [7:0] ai, input logic [7:0] bi,
                        input logic [7:0] ey, input logic ec, input bit poke);
        int lat;
`ifdef ALU_SERIAL_FLAGS_EN
        logic [7:0] bb;
`endif
        l8 = li; s8 = si; ci8 = ci; a8 = ai; b8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; l8 = ~li; s8 = ~si; ci8 = ~ci; a8 = ~ai; b8 = 8'($urandom);
        lat = 1;
        check({tag, ".busy"}, 64'(busy8), 64'd1);
        while (!done8 && lat < 20) begin
            if (poke && lat == 3) begin
                start8 = 1'b1; l8 = 1'b1; s8 = 2'b00; a8 = 8'h33; b8 = 8'h44;
            end else begin
                start8 = 1'b0;
            end
            if (lat == 5) check({tag, ".hold"}, 64'(y8), 64'(prev_y));
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'd9);
        check({tag, ".y"}, 64'(y8), 64'(ey));
        check({tag, ".c"}, 64'(c8), 64'(ec));
`ifdef ALU_SERIAL_FLAGS_EN
        bb = (si == 2'b01) ? ~bi : (si == 2'b11) ? 8'h00 : bi;
        check({tag, ".zf"}, 64'(zf8), 64'(ey == 8'h00));
        check({tag, ".vf"}, 64'(vf8), 64'(li & (ai[7] == bb[7]) & (ey[7] != ai[7])));
`endif
        prev_y = ey;
        @(posedge clk); #1;
        check({tag, ".pulse"}, 64'({done8, busy8}), 64'd0);
    endtask

    task automatic pick32();
        logic [32:0] sum;
        a32 = $urandom; b32 = $urandom;
        s32 = 2'($urandom_range(0, 1));
        ci32 = 1'($urandom_range(0, 1));
        sum = (s32 == 2'b01) ? ({1'b0, a32} + {1'b0, ~b32} + 33'd1) : ({1'b0, a32} + {1'b0, b32});
        q_y.push_back(sum[31:0]);
        q_c.push_back(sum[32]);
        pushed++;
    endtask

    initial begin
        int dones;
        int got;
        int last_done;
        #3;
        check("rst.outs", 64'({busy8, done8, c8, y8}), 64'd0);
        check("rst.outs32", 64'({busy32, done32, c32, y32}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run8("add_ff_01",  1'b1, 2'b00, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run8("xor_a5_0f",  1'b0, 2'b10, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0);
        run8("not_a5",     1'b0, 2'b11, 1'b0, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0);
        run8("and_a5_0f",  1'b0, 2'b00, 1'b1, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0);
        run8("or_a5_0f",   1'b0, 2'b01, 1'b0, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0);
        run8("sub_80_01",  1'b1, 2'b01, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
        run8("adc_0f_01",  1'b1, 2'b10, 1'b1, 8'h0F, 8'h01, 8'h11, 1'b0, 1'b0);
        run8("adc_ff_ff",  1'b1, 2'b10, 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
        run8("add_nocin",  1'b1, 2'b00, 1'b1, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        run8("add_7f_01",  1'b1, 2'b00, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
        run8("sub_borrow", 1'b1, 2'b01, 1'b0, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0);
        run8("inc_7f",     1'b1, 2'b11, 1'b0, 8'h7F, 8'h55, 8'h80, 1'b0, 1'b0);
        run8("inc_ff",     1'b1, 2'b11, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);

        run8("poke_add",   1'b1, 2'b00, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        check("poke.extra_done", 64'(dones), 64'd0);

        l8 = 1'b1; s8 = 2'b00; ci8 = 1'b0; a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.outs", 64'({busy8, done8, c8, y8}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        prev_y = 8'h00;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        check("midrst.no_done", 64'(dones), 64'd0);
        check("midrst.y_held", 64'(y8), 64'd0);
        run8("post_rst_sub", 1'b1, 2'b01, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);

        got = 0;
        last_done = -1;
        start32 = 1'b1;
        pick32();
        for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
            @(posedge clk); #1;
            if (done32) begin
                if (q_y.size() == 0) begin
                    check("b2b.extra_done", 64'd1, 64'd0);
                end else begin
                    check("b2b.y", 64'(y32), 64'(q_y.pop_front()));
                    check("b2b.c", 64'(c32), 64'(q_c.pop_front()));
                end
                if (last_done >= 0) check("b2b.gap", 64'(cyc - last_done), 64'd34);
                last_done = cyc;
                got++;
            end
            if (!busy32) begin
                if (pushed < 1000) pick32();
                else start32 = 1'b0;
            end
        end
        start32 = 1'b0;
        check("b2b.count", 64'(got), 64'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 l  input  1  mode: 0 = logic, 1 = arithmetic; captured on start.
REQ-008 s  input  2  operation select; captured on start.
REQ-009 c_in  input  1  carry input, captured on start.
REQ-010 busy  output  1  high in BUSY and DONE.
REQ-011 done  output  1  one-cycle pulse when the result is valid.
REQ-012 y  output  WIDTH  result register.
REQ-013 c_out  output  1  final carry (arithmetic); 0 in logic mode.
REQ-014 zf, vf  output  1 each  zero and signed-overflow flags (only when ALU_SERIAL_FLAGS_EN is defined).

Function
REQ-015 Logic ops (l=0): s=00 AND, 01 OR, 10 XOR, 11 NOT A.
REQ-016 Arithmetic ops (l=1): s=00 A+B (carry-in 0), 01 A-B (A + ~B, carry-in 1), 10 A+B+c_in, 11 A+1.
REQ-017 Processing is bit-serial, LSB first, one bit per clock, through one 1-bit cell with a carry flip-flop.
REQ-018 FSM states IDLE, BUSY, DONE; IDLE->BUSY on start=1; BUSY->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-019 Start accepted at edge k: operands latched; bits 0..WIDTH-1 computed on edges k+1..k+WIDTH; done=1 for exactly the cycle after edge k+WIDTH; latency is WIDTH+1 cycles.
REQ-020 start while busy=1 is ignored; no queuing, no error.
REQ-021 The bit counter is $clog2(WIDTH) bits wide and compares against WIDTH-1; no wrap past WIDTH-1.
REQ-022 y and c_out update only in the cycle done rises and hold until the next done; intermediate bits are not visible on y.
REQ-023 c_out = carry out of bit WIDTH-1; for SUB, 1 means no borrow.
REQ-024 Operand inputs may change at any time after acceptance without affecting the result.
REQ-025 Back-to-back: start held high yields a new acceptance in the IDLE cycle after DONE; throughput is one result per WIDTH+2 cycles.

Reset
REQ-026 rst_n=0 forces IDLE, counter 0, carry flip-flop 0, busy 0, done 0, y 0, c_out 0, zf 0, vf 0 immediately, without a clock.
REQ-027 Reset mid-operation discards the operation; no done pulse follows; y holds 0.
REQ-028 The first acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_SERIAL_FLAGS_EN: if defined, zf = (y==0) and vf = signed overflow of ADD/SUB/ADC/INC (0 in logic mode), both updated with y; if undefined, the zf/vf ports and their logic are absent.

Structure
REQ-030 Package alu_serial_pkg holds the state enum (IDLE, BUSY, DONE) and the operation-code constants for {l,s}.
REQ-031 One sub-module, alu_bit_cell: combinational 1-bit logic/adder cell (inputs a, b, cin, l, s; outputs r, cout), instantiated once.

Verification
REQ-032 WIDTH=8, l=1 s=00, a=8'hFF b=8'h01 -> after 9 cycles done=1, y=8'h00, c_out=1, zf=1, vf=0.
REQ-033 l=1 s=01, a=8'h80 b=8'h01 -> y=8'h7F, c_out=1, vf=1; l=1 s=10 c_in=1, a=8'h0F b=8'h01 -> y=8'h11.
REQ-034 l=0 s=10, a=8'hA5 b=8'h0F -> y=8'hAA, c_out=0; s=11 -> y=8'h5A.
REQ-035 Start pulsed again during BUSY with different operands -> first result unchanged, only one done pulse.
REQ-036 rst_n low at bit 4 of an operation -> busy=0, y=0 immediately; no done; next start completes normally.
REQ-037 WIDTH=32 random ADD/SUB against a reference model, 1000 operations, with start held high -> all match; spacing is 34 cycles.
